// File: rtl/bus_rd_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : bus_rd_seq_if
// Purpose  : Request and device-bus signal bundle for the read sequencer.
//            The slave modport is the sequencer's view; the master modport is
//            the view of the environment (requester plus read devices).
// Revision : 1.0  initial release
// ============================================================================
interface bus_rd_seq_if #(
  parameter int NUM_DEV = 4
);
  // requester side
  logic                   iReq;
  logic [19:0]            iAddr;
  logic                   oReady;
  logic                   oAck;
  logic [7:0]             oData;
  logic                   oMiss;
  // device side
  logic [19:0]            oAddr;
  logic                   oRd;
  logic [NUM_DEV-1:0]     iSel;
  logic [8*NUM_DEV-1:0]   iData;

  modport slave (
    input  iReq, iAddr, iSel, iData,
    output oReady, oAck, oData, oMiss, oAddr, oRd
  );

  modport master (
    output iReq, iAddr, iSel, iData,
    input  oReady, oAck, oData, oMiss, oAddr, oRd
  );
endinterface
`default_nettype wire

// File: rtl/bus_rd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bus_rd_seq
// Purpose  : CPU-side memory read sequencer. Issues a one-cycle read strobe
//            with a latched address, captures the registered device returns
//            one cycle later, merges them into one byte (lowest index wins,
//            open-bus value when nothing selects) and acknowledges.
// Revision : 1.0  initial release
// ============================================================================
module bus_rd_seq #(
  parameter int         NUM_DEV  = 4,      // 1..8, index 0 is the BIOS ROM
  parameter logic [7:0] OPEN_BUS = 8'hFF
) (
  input  wire logic       iClk,
  input  wire logic       iRst,
  bus_rd_seq_if.slave     bus,
  output logic            oErrMulti,
  output logic            oOverrun
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  state_t               rState;
  logic                 rReady;
  logic                 rRd;
  logic                 rAck;
  logic                 rMiss;
  logic [7:0]           rData;
  logic [19:0]          rAddr;
  logic                 rErrMulti;
  logic                 rOverrun;

  logic [NUM_DEV-1:0]   wSel;
  logic                 wHit;
  logic                 wMulti;
  logic [7:0]           wByte;

  assign wSel = bus.iSel;

  // Merge device returns: scanning from the top index down lets the lowest
  // selected device overwrite the others, so it wins on a conflict.
  always_comb begin
    wHit  = 1'b0;
    wByte = OPEN_BUS;
    for (int k = NUM_DEV - 1; k >= 0; k--) begin
      if (wSel[k]) begin
        wHit  = 1'b1;
        wByte = bus.iData[8*k +: 8];
      end
    end
  end

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign wMulti = |(wSel & (wSel - NUM_DEV'(1)));

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      rState    <= ST_IDLE;
      rReady    <= 1'b1;
      rRd       <= 1'b0;
      rAck      <= 1'b0;
      rMiss     <= 1'b0;
      rData     <= OPEN_BUS;
      rAddr     <= 20'd0;
      rErrMulti <= 1'b0;
      rOverrun  <= 1'b0;
    end else begin
      rRd  <= 1'b0;
      rAck <= 1'b0;

      // rReady mirrors IDLE, so a request seen while it is low is dropped.
      if (bus.iReq && !rReady) begin
        rOverrun <= 1'b1;
      end

      case (rState)
        ST_IDLE: begin
          if (bus.iReq) begin
            rAddr  <= bus.iAddr;
            rRd    <= 1'b1;
            rReady <= 1'b0;
            rState <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          rState <= ST_CAPTURE;
        end

        ST_CAPTURE: begin
          rData  <= wByte;
          rMiss  <= !wHit;
          rAck   <= 1'b1;
          rReady <= 1'b1;
          rState <= ST_IDLE;
          if (wMulti) begin
            rErrMulti <= 1'b1;
          end
        end

        default: begin
          rReady <= 1'b1;
          rState <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.oReady = rReady;
  assign bus.oRd    = rRd;
  assign bus.oAck   = rAck;
  assign bus.oMiss  = rMiss;
  assign bus.oData  = rData;
  assign bus.oAddr  = rAddr;
  assign oErrMulti  = rErrMulti;
  assign oOverrun   = rOverrun;

endmodule
`default_nettype wire

// File: tb/tb_bus_rd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_rd_seq
// Purpose  : Directed bench for bus_rd_seq with a transaction-level model
//            compared against the DUT every cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_bus_rd_seq;

  localparam int NUM_DEV = 4;

  logic iClk;
  logic iRst;
  logic errMulti;
  logic overrun;

  int checks = 0;
  int errors = 0;

  bus_rd_seq_if #(.NUM_DEV(NUM_DEV)) ifc ();

  bus_rd_seq #(.NUM_DEV(NUM_DEV), .OPEN_BUS(8'hFF)) dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .bus       (ifc),
    .oErrMulti (errMulti),
    .oOverrun  (overrun)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // A read accepted at edge n is strobed in the next cycle, captured at edge
  // n+2 and acknowledged in the cycle after that.
  int          cyc = 0;
  int          mT;
  bit          mValid = 0;
  bit          pending;
  bit          idleNow;
  bit          capNow;
  bit          found;
  logic        eReady, eRd, eAck, eMiss, eErr, eOvr;
  logic [7:0]  eData;
  logic [19:0] eAddr;

  always @(posedge iClk) begin
    if (iRst) begin
      mValid  = 1;
      pending = 0;
      eReady  = 1; eRd = 0; eAck = 0; eMiss = 0;
      eData   = 8'hFF; eAddr = 20'd0; eErr = 0; eOvr = 0;
    end else if (mValid) begin
      idleNow = !pending;
      capNow  = pending && (cyc == mT + 2);
      eRd  = 0;
      eAck = 0;
      if (ifc.iReq) begin
        if (idleNow) begin
          pending = 1;
          mT      = cyc;
          eAddr   = ifc.iAddr;
          eRd     = 1;
        end else begin
          eOvr = 1;
        end
      end
      if (capNow) begin
        found = 0;
        for (int k = 0; k < NUM_DEV; k++) begin
          if (!found && ifc.iSel[k]) begin
            found = 1;
            eData = ifc.iData[8*k +: 8];
          end
        end
        if (!found) eData = 8'hFF;
        eMiss = !found;
        if ($countones(ifc.iSel) > 1) eErr = 1;
        eAck    = 1;
        pending = 0;
      end
      eReady = !pending;
    end
    cyc++;
  end

  // Compare every output against the model half a cycle after each edge.
  always @(negedge iClk) begin
    if (mValid) begin
      chk("m_ready", ifc.oReady, eReady);
      chk("m_rd",    ifc.oRd,    eRd);
      chk("m_ack",   ifc.oAck,   eAck);
      chk("m_data",  ifc.oData,  eData);
      chk("m_miss",  ifc.oMiss,  eMiss);
      chk("m_addr",  ifc.oAddr,  eAddr);
      chk("m_err",   errMulti,   eErr);
      chk("m_ovr",   overrun,    eOvr);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge iClk);
    #2;
  endtask

  task automatic sample();
    #3;
  endtask

  task automatic rd(input logic [19:0] addr, input logic [3:0] sel,
                    input logic [31:0] data, input logic [7:0] expData,
                    input logic expMiss);
    step(); ifc.iReq = 1'b1; ifc.iAddr = addr;
    step(); ifc.iReq = 1'b0;
    sample(); chk("rd_strobe", ifc.oRd, 1'b1); chk("rd_addr", ifc.oAddr, addr);
    step(); ifc.iSel = sel; ifc.iData = data;
    sample(); chk("rd_noack_early", ifc.oAck, 1'b0); chk("rd_rd_single", ifc.oRd, 1'b0);
    step(); ifc.iSel = '0; ifc.iData = '0;
    sample();
    chk("rd_ack",   ifc.oAck,   1'b1);
    chk("rd_data",  ifc.oData,  expData);
    chk("rd_miss",  ifc.oMiss,  expMiss);
    chk("rd_ready", ifc.oReady, 1'b1);
  endtask

  initial begin
    ifc.iReq = 1'b0; ifc.iAddr = '0; ifc.iSel = '0; ifc.iData = '0;
    iRst = 1'b1;
    step(); step();
    iRst = 1'b0;
    sample();
    chk("rst_ready", ifc.oReady, 1'b1);
    chk("rst_rd",    ifc.oRd,    1'b0);
    chk("rst_ack",   ifc.oAck,   1'b0);
    chk("rst_data",  ifc.oData,  8'hFF);
    chk("rst_addr",  ifc.oAddr,  20'h0);
    chk("rst_flags", {errMulti, overrun}, 2'b00);

    // BIOS hit, open-bus miss, then a two-device conflict
    rd(20'hFE005, 4'b0001, 32'h000000EA, 8'hEA, 1'b0);
    chk("bios_err", errMulti, 1'b0);
    rd(20'hC0000, 4'b0000, 32'h12345678, 8'hFF, 1'b1);
    chk("miss_err", errMulti, 1'b0);
    rd(20'h0A000, 4'b0110, 32'h00221100, 8'h11, 1'b0);
    chk("multi_err", errMulti, 1'b1);

    // Back-to-back with iReq held high
    step(); ifc.iReq = 1'b1; ifc.iAddr = 20'hFFFF0;              // T
    step(); sample(); chk("b2b_rd1", ifc.oRd, 1'b1); chk("b2b_addr1", ifc.oAddr, 20'hFFFF0);
    step(); ifc.iSel = 4'b0001; ifc.iData = 32'h0000005A;          // T+2
    sample(); chk("b2b_rd_gap", ifc.oRd, 1'b0);
    step(); ifc.iSel = '0; ifc.iData = '0; ifc.iAddr = 20'hFFFF1;  // T+3
    sample();
    chk("b2b_ack1",  ifc.oAck,  1'b1);
    chk("b2b_data1", ifc.oData, 8'h5A);
    chk("b2b_ovr",   overrun,   1'b1);
    step(); ifc.iReq = 1'b0;                                       // T+4
    sample(); chk("b2b_rd2", ifc.oRd, 1'b1); chk("b2b_addr2", ifc.oAddr, 20'hFFFF1);
    step(); ifc.iSel = 4'b0010; ifc.iData = 32'h0000A500;          // T+5
    step(); ifc.iSel = '0; ifc.iData = '0;                         // T+6
    sample();
    chk("b2b_ack2",  ifc.oAck,  1'b1);
    chk("b2b_data2", ifc.oData, 8'hA5);
    chk("b2b_err_sticky", errMulti, 1'b1);

    // Reset during ISSUE, device still answers afterwards
    step(); ifc.iReq = 1'b1; ifc.iAddr = 20'h12345;
    step(); ifc.iReq = 1'b0; iRst = 1'b1;
    sample(); chk("abort_rd", ifc.oRd, 1'b1);
    step(); iRst = 1'b0; ifc.iSel = 4'b0001; ifc.iData = 32'h000000EA;
    sample();
    chk("abort_ready", ifc.oReady, 1'b1);
    chk("abort_ack",   ifc.oAck,   1'b0);
    chk("abort_data",  ifc.oData,  8'hFF);
    chk("abort_flags", {errMulti, overrun}, 2'b00);
    step(); ifc.iSel = '0; ifc.iData = '0;
    sample(); chk("abort_noack", ifc.oAck, 1'b0); chk("abort_nord", ifc.oRd, 1'b0);

    // Request together with reset is dropped silently
    step(); iRst = 1'b1; ifc.iReq = 1'b1; ifc.iAddr = 20'h55555;
    step(); iRst = 1'b0; ifc.iReq = 1'b0;
    sample();
    chk("rstreq_rd",   ifc.oRd,   1'b0);
    chk("rstreq_ovr",  overrun,   1'b0);
    chk("rstreq_addr", ifc.oAddr, 20'h0);

    // Stray selects with nothing in flight
    step(); ifc.iSel = 4'b1111; ifc.iData = 32'hDEADBEEF;
    step(); ifc.iSel = '0; ifc.iData = '0;
    step(); step();
    sample();
    chk("stray_ack",   ifc.oAck,  1'b0);
    chk("stray_data",  ifc.oData, 8'hFF);
    chk("stray_flags", {errMulti, overrun, ifc.oMiss}, 3'b000);

    // Highest device alone still works after everything above
    rd(20'h00001, 4'b1000, 32'h77000000, 8'h77, 1'b0);

    step(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
